core_store_buffer: RTL and testbench

//  Parametrised FIFO store buffer between the MEM stage and the data memory.

---
 rtl/core_store_buffer_pkg.sv | 18 +
 rtl/core_sb_lookup.sv | 41 ++++
 rtl/core_store_buffer.sv | 136 +++++++++++++
 tb/tb_core_store_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_store_buffer_pkg.sv
// Shared types for the core store buffer: the entry record, the default depth
// and the lookup outcome encoding.
package core_store_buffer_pkg;

  localparam int SB_ADDR_W    = 32;
  localparam int SB_DATA_W    = 32;
  localparam int SB_BYTES_DEF = SB_DATA_W / 8;
  localparam int SB_DEPTH_DEF = 4;

  typedef struct packed {
    logic [SB_ADDR_W-3:0]    word;
    logic [SB_DATA_W-1:0]    data;
    logic [SB_BYTES_DEF-1:0] be;
  } sb_entry_t;

  typedef enum logic [1:0] {SB_MISS, SB_HIT, SB_CONFLICT} sb_lookup_t;

endpackage

// File: rtl/core_sb_lookup.sv
// Combinational store-to-load forwarding search. It walks the entries oldest
// to youngest starting at the head, so a younger matching byte overwrites an older one.
module core_sb_lookup
  import core_store_buffer_pkg::*;
#(
  parameter int  SB_DEPTH = SB_DEPTH_DEF,
  parameter int  WORD_W   = SB_ADDR_W - 2,
  parameter int  DATA_W   = SB_DATA_W,
  parameter type entry_t  = sb_entry_t,
  localparam int SB_BYTES = DATA_W / 8,
  localparam int PTR_W    = $clog2(SB_DEPTH)
) (
  input  entry_t              i_entries [SB_DEPTH],
  input  logic [SB_DEPTH-1:0] i_valid,
  input  logic [PTR_W-1:0]    i_head,
  input  logic [WORD_W-1:0]   i_ld_word,
  input  logic [SB_BYTES-1:0] i_ld_be,
  output logic [SB_BYTES-1:0] o_covered,
  output logic [DATA_W-1:0]   o_data
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_covered = '0;
    o_data    = '0;
    w_idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (i_valid[w_idx] && (i_entries[w_idx].word == i_ld_word)) begin
        for (int b = 0; b < SB_BYTES; b++) begin
          if (i_entries[w_idx].be[b] && i_ld_be[b]) begin
            o_covered[b]     = 1'b1;
            o_data[8*b +: 8] = i_entries[w_idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/core_store_buffer.sv
// In-order store buffer between MEM and data memory: FIFO storage, drain port,
// optional coalescing into the youngest non-head entry, and load forwarding.
module core_store_buffer
  import core_store_buffer_pkg::*;
#(
  parameter int  SB_DEPTH = SB_DEPTH_DEF,
  parameter int  ADDR_W   = 32,
  parameter int  DATA_W   = 32,
  parameter int  COALESCE = 1,
  localparam int SB_BYTES = DATA_W / 8,
  localparam int CNT_W    = $clog2(SB_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_st_valid,
  output logic                o_st_ready,
  input  logic [ADDR_W-1:0]   i_st_addr,
  input  logic [DATA_W-1:0]   i_st_wdata,
  input  logic [SB_BYTES-1:0] i_st_be,
  input  logic                i_ld_valid,
  input  logic [ADDR_W-1:0]   i_ld_addr,
  input  logic [SB_BYTES-1:0] i_ld_be,
  output logic                o_ld_hit,
  output logic                o_ld_conflict,
  output logic [DATA_W-1:0]   o_ld_fwd_data,
  output logic                o_dm_req,
  input  logic                i_dm_gnt,
  output logic [ADDR_W-1:0]   o_dm_addr,
  output logic [DATA_W-1:0]   o_dm_wdata,
  output logic [SB_BYTES-1:0] o_dm_be,
  output logic                o_sb_empty,
  output logic [CNT_W-1:0]    o_sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [ADDR_W-3:0]   word;
    logic [DATA_W-1:0]   data;
    logic [SB_BYTES-1:0] be;
  } entry_t;

  entry_t              r_entries [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_full, w_empty, w_push, w_pop, w_coal, w_alloc;
  logic [PTR_W-1:0]    w_prev;
  logic [ADDR_W-3:0]   w_st_word;
  entry_t              w_merged;
  logic [SB_BYTES-1:0] w_covered;
  logic [DATA_W-1:0]   w_fwd;
  sb_lookup_t          w_lookup;
  logic                w_unused_addr_lsb;

  assign w_full    = (r_count == CNT_W'(SB_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_st_word = i_st_addr[ADDR_W-1:2];
  assign w_prev    = r_tail - PTR_W'(1);
  assign w_push    = i_st_valid && !w_full;
  assign w_pop     = !w_empty && i_dm_gnt;
  // Needing two entries keeps the head, which may be mid-drain, out of the merge.
  assign w_coal    = (COALESCE != 0) && w_push && (r_count >= CNT_W'(2)) &&
                     (r_entries[w_prev].word == w_st_word);
  assign w_alloc   = w_push && !w_coal;

  always_comb begin
    w_merged    = r_entries[w_prev];
    w_merged.be = r_entries[w_prev].be | i_st_be;
    for (int b = 0; b < SB_BYTES; b++) begin
      if (i_st_be[b]) w_merged.data[8*b +: 8] = i_st_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_alloc) r_entries[r_tail] <= '{word: w_st_word, data: i_st_wdata, be: i_st_be};
    if (w_coal)  r_entries[w_prev] <= w_merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  core_sb_lookup #(
    .SB_DEPTH (SB_DEPTH),
    .WORD_W   (ADDR_W - 2),
    .DATA_W   (DATA_W),
    .entry_t  (entry_t)
  ) u_lookup (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_ld_word (i_ld_addr[ADDR_W-1:2]),
    .i_ld_be   (i_ld_be),
    .o_covered (w_covered),
    .o_data    (w_fwd)
  );

  always_comb begin
    w_lookup = SB_MISS;
    if (i_ld_valid && (w_covered != '0))
      w_lookup = (w_covered == i_ld_be) ? SB_HIT : SB_CONFLICT;
  end

  assign o_ld_hit      = (w_lookup == SB_HIT);
  assign o_ld_conflict = (w_lookup == SB_CONFLICT);
  assign o_ld_fwd_data = i_ld_valid ? w_fwd : '0;

  assign o_st_ready = !w_full;
  assign o_dm_req   = !w_empty;
  assign o_dm_addr  = o_dm_req ? {r_entries[r_head].word, 2'b00} : '0;
  assign o_dm_wdata = o_dm_req ? r_entries[r_head].data : '0;
  assign o_dm_be    = o_dm_req ? r_entries[r_head].be : '0;
  assign o_sb_empty = w_empty;
  assign o_sb_count = r_count;

  assign w_unused_addr_lsb = ^{i_st_addr[1:0], i_ld_addr[1:0]};

endmodule

// File: tb/tb_core_store_buffer.sv
// Bench for core_store_buffer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_core_store_buffer;

  localparam int DEPTH = 4;
  localparam int COAL  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_be;
  logic        ld_valid, ld_hit, ld_conflict;
  logic [31:0] ld_addr, ld_fwd_data;
  logic [3:0]  ld_be;
  logic        dm_req, dm_gnt;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        sb_empty;
  logic [2:0]  sb_count;

  core_store_buffer #(.SB_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .COALESCE(COAL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_st_valid(st_valid), .o_st_ready(st_ready), .i_st_addr(st_addr),
    .i_st_wdata(st_wdata), .i_st_be(st_be),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_be(ld_be),
    .o_ld_hit(ld_hit), .o_ld_conflict(ld_conflict), .o_ld_fwd_data(ld_fwd_data),
    .o_dm_req(dm_req), .i_dm_gnt(dm_gnt), .o_dm_addr(dm_addr),
    .o_dm_wdata(dm_wdata), .o_dm_be(dm_be),
    .o_sb_empty(sb_empty), .o_sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } m_ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  m_ent_t mq[$];
  wr_t    wlog[$];
  bit     model_ok = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a program-ordered list of pending word writes.
  always @(posedge clk) begin
    int n;
    bit push, pop, coal;
    m_ent_t e;
    if (rst) begin
      mq.delete();
      model_ok = 1;
    end else if (model_ok) begin
      n    = mq.size();
      pop  = (n > 0) && dm_gnt;
      push = st_valid && (n < DEPTH);
      coal = push && (COAL != 0) && (n >= 2) && (mq[n-1].word == st_addr[31:2]);
      if (coal) begin
        for (int b = 0; b < 4; b++)
          if (st_be[b]) mq[n-1].data[8*b +: 8] = st_wdata[8*b +: 8];
        mq[n-1].be = mq[n-1].be | st_be;
      end
      if (pop) void'(mq.pop_front());
      if (push && !coal) begin
        e.word = st_addr[31:2];
        e.data = st_wdata;
        e.be   = st_be;
        mq.push_back(e);
      end
    end
  end

  // Per-cycle compare against the model, plus a log of every write the DUT issues.
  always @(negedge clk) begin
    logic [3:0]  cov;
    logic [31:0] fwd;
    bit          found;
    if (!rst && model_ok) begin
      cov = '0;
      fwd = '0;
      if (ld_valid) begin
        for (int b = 0; b < 4; b++) begin
          found = 0;
          for (int k = mq.size() - 1; k >= 0 && !found; k--) begin
            if (ld_be[b] && mq[k].word == ld_addr[31:2] && mq[k].be[b]) begin
              found = 1;
              cov[b] = 1'b1;
              fwd[8*b +: 8] = mq[k].data[8*b +: 8];
            end
          end
        end
      end
      chk("cyc_st_ready", 64'(st_ready), 64'(mq.size() < DEPTH));
      chk("cyc_dm_req",   64'(dm_req),   64'(mq.size() > 0));
      chk("cyc_sb_empty", 64'(sb_empty), 64'(mq.size() == 0));
      chk("cyc_sb_count", 64'(sb_count), 64'(mq.size()));
      chk("cyc_ld_hit",   64'(ld_hit),   64'(ld_valid && cov != 0 && cov == ld_be));
      chk("cyc_ld_conf",  64'(ld_conflict), 64'(ld_valid && cov != 0 && cov != ld_be));
      if (ld_valid) chk("cyc_ld_fwd", 64'(ld_fwd_data), 64'(fwd));
      if (mq.size() > 0) begin
        chk("cyc_dm_addr",  64'(dm_addr),  64'({mq[0].word, 2'b00}));
        chk("cyc_dm_wdata", 64'(dm_wdata), 64'(mq[0].data));
        chk("cyc_dm_be",    64'(dm_be),    64'(mq[0].be));
      end
      if (dm_req && dm_gnt) wlog.push_back('{addr: dm_addr, data: dm_wdata, be: dm_be});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = be;
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    if (idx < wlog.size()) begin
      chk({nm, "_addr"}, 64'(wlog[idx].addr), 64'(a));
      chk({nm, "_data"}, 64'(wlog[idx].data), 64'(d));
      chk({nm, "_be"},   64'(wlog[idx].be),   64'(be));
    end else begin
      chk({nm, "_present"}, 64'(wlog.size()), 64'(idx + 1));
    end
  endtask

  task automatic drain(input int budget);
    int k;
    dm_gnt = 1'b1;
    k = 0;
    while (!sb_empty && k < budget) begin
      cyc();
      k++;
    end
    dm_gnt = 1'b0;
    chk("drain_done", 64'(sb_empty), 64'(1));
  endtask

  initial begin
    rst = 1'b1; st_valid = 0; st_addr = 0; st_wdata = 0; st_be = 0;
    ld_valid = 0; ld_addr = 0; ld_be = 0; dm_gnt = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset / idle
    chk("rst_dm_req", 64'(dm_req), 64'(0));
    chk("rst_empty",  64'(sb_empty), 64'(1));
    chk("rst_ready",  64'(st_ready), 64'(1));
    chk("rst_count",  64'(sb_count), 64'(0));
    chk("rst_hit",    64'(ld_hit), 64'(0));
    chk("rst_conf",   64'(ld_conflict), 64'(0));
    chk("rst_fwd",    64'(ld_fwd_data), 64'(0));

    // Single word store, forward, then drain
    store(32'h1000, 32'hDEADBEEF, 4'hF);
    ld_valid = 1; ld_addr = 32'h1000; ld_be = 4'hF;
    #1;
    chk("sw_hit", 64'(ld_hit), 64'(1));
    chk("sw_fwd", 64'(ld_fwd_data), 64'(32'hDEADBEEF));
    chk("sw_count", 64'(sb_count), 64'(1));
    ld_valid = 0;
    dm_gnt = 1;
    #1;
    chk("sw_dm_addr", 64'(dm_addr), 64'(32'h1000));
    cyc();
    dm_gnt = 0;
    #1;
    chk("sw_empty", 64'(sb_empty), 64'(1));
    chk("sw_nwr", 64'(wlog.size()), 64'(1));
    chk_wr("sw_wr", 0, 32'h1000, 32'hDEADBEEF, 4'hF);

    // Byte overlay, then a coalescing store into the non-head entry
    wlog.delete();
    store(32'h2000, 32'h11223344, 4'hF);
    store(32'h2001, 32'h0000AA00, 4'h2);
    ld_valid = 1; ld_addr = 32'h2000; ld_be = 4'hF;
    #1;
    chk("sb_hit", 64'(ld_hit), 64'(1));
    chk("sb_fwd", 64'(ld_fwd_data), 64'(32'h1122AA44));
    chk("sb_count", 64'(sb_count), 64'(2));
    st_valid = 1; st_addr = 32'h2003; st_wdata = 32'h77000000; st_be = 4'h8;
    #1;
    chk("same_cyc_fwd", 64'(ld_fwd_data), 64'(32'h1122AA44));
    cyc();
    st_valid = 0;
    #1;
    chk("coal_count", 64'(sb_count), 64'(2));
    chk("coal_fwd", 64'(ld_fwd_data), 64'(32'h7722AA44));
    ld_valid = 0;
    drain(10);
    chk("coal_nwr", 64'(wlog.size()), 64'(2));
    chk_wr("coal_wr0", 0, 32'h2000, 32'h11223344, 4'hF);
    chk_wr("coal_wr1", 1, 32'h2000, 32'h7700AA00, 4'hA);

    // Partial coverage -> conflict
    store(32'h3002, 32'h00550000, 4'h4);
    ld_valid = 1; ld_addr = 32'h3000; ld_be = 4'hF;
    #1;
    chk("cf_conf", 64'(ld_conflict), 64'(1));
    chk("cf_hit", 64'(ld_hit), 64'(0));
    drain(10);
    #1;
    chk("cf_conf_after", 64'(ld_conflict), 64'(0));
    chk("cf_hit_after", 64'(ld_hit), 64'(0));
    ld_valid = 0;

    // Full buffer, no same-cycle slot reuse, then wrap with back-to-back retires
    wlog.delete();
    for (int i = 0; i < 4; i++) store(32'h4000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
    #1;
    chk("full_ready", 64'(st_ready), 64'(0));
    chk("full_count", 64'(sb_count), 64'(4));
    st_valid = 1; st_addr = 32'h4010; st_wdata = 32'hBB; st_be = 4'hF; dm_gnt = 1;
    #1;
    chk("full_ready_gnt", 64'(st_ready), 64'(0));
    cyc();
    st_valid = 0; dm_gnt = 0;
    #1;
    chk("full_count_after", 64'(sb_count), 64'(3));
    dm_gnt = 1;
    for (int i = 0; i < 8; i++) store(32'h5000 + 32'(4*i), 32'hC0 + 32'(i), 4'hF);
    drain(20);
    chk("wrap_nwr", 64'(wlog.size()), 64'(12));
    for (int i = 0; i < 4; i++) chk_wr("wrap_a", i, 32'h4000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) chk_wr("wrap_b", 4 + i, 32'h5000 + 32'(4*i), 32'hC0 + 32'(i), 4'hF);

    // Reset with pending stores discards them
    for (int i = 0; i < 3; i++) store(32'h6000 + 32'(4*i), 32'hD0 + 32'(i), 4'hF);
    #1;
    chk("pre_rst_count", 64'(sb_count), 64'(3));
    wlog.delete();
    rst = 1;
    cyc();
    rst = 0;
    ld_valid = 1; ld_addr = 32'h6000; ld_be = 4'hF;
    #1;
    chk("mrst_empty", 64'(sb_empty), 64'(1));
    chk("mrst_dm_req", 64'(dm_req), 64'(0));
    chk("mrst_hit", 64'(ld_hit), 64'(0));
    chk("mrst_conf", 64'(ld_conflict), 64'(0));
    dm_gnt = 1;
    cyc(); cyc(); cyc();
    dm_gnt = 0; ld_valid = 0;
    chk("mrst_nwr", 64'(wlog.size()), 64'(0));

    // Mixed traffic on two words; the per-cycle model carries the checking
    for (int i = 0; i < 80; i++) begin
      st_valid = ($urandom_range(0, 2) != 0);
      st_addr  = 32'h7000 + 32'($urandom_range(0, 1) * 4) + 32'($urandom_range(0, 3));
      st_wdata = $urandom;
      st_be    = 4'($urandom_range(1, 15));
      dm_gnt   = ($urandom_range(0, 2) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 32'h7000 + 32'($urandom_range(0, 1) * 4);
      ld_be    = 4'($urandom_range(0, 15));
      cyc();
    end
    st_valid = 0; ld_valid = 0;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
